// File: rtl/arb_defs.sv
// Shared encodings for the memory port arbiter: FSM states, transfer owners
// and the timeout counter width.
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } arb_owner_e;

  // Wide enough for any practical response timeout (limit < 65536)
  localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Response timeout counter shared by bus masters: counts enabled cycles since
// the last clear and flags the cycle in which the count reaches the limit.
// A limit of zero disables expiry.
module arb_timeout_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end
  end

  // Expiry in the enabled cycle that brings the count up to the limit
  always_comb begin
    expired_c = en_i && (limit_i != '0) && (cnt_d == limit_i) && !clear_i;
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core-side memory port between instruction fetch (read-only) and
// load/store. Each transfer runs IDLE -> REQ -> RSP -> DONE; done/err/rdata
// and the bus request are registered, stalls are combinational.
// Optional: define ARB_ROUND_ROBIN_EN to alternate grants when both sides
// are pending; otherwise MEM always wins over IF.
module mem_port_arbiter
  import arb_defs::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  output logic                if_stall_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_done_o,
  output logic                mem_stall_o,
  output logic                err_o,
  output logic                bus_valid_o,
  input  logic                bus_ready_i,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_rsp_valid_i,
  input  logic                bus_rsp_err_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYC);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q, owner_d;
  arb_owner_e          grant_c;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic                err_q, err_d;
  logic                cnt_clr_c;
  logic                cnt_en_c;
  logic                tmo_expired_c;
`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e          last_owner_q, last_owner_d;
`endif

  // Response timeout counter, running only while waiting in RSP
  arb_timeout_cnt #(
    .CNT_W (TMO_CNT_W)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clr_c),
    .en_i      (cnt_en_c),
    .limit_i   (TMO_LIMIT),
    .expired_c (tmo_expired_c)
  );

  // Arbitration between pending requesters
  always_comb begin
    grant_c = OWN_NONE;
    if (mem_req_i && if_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_c = (last_owner_q == OWN_MEM) ? OWN_IF : OWN_MEM;
`else
      grant_c = OWN_MEM;
`endif
    end else if (mem_req_i) begin
      grant_c = OWN_MEM;
    end else if (if_req_i) begin
      grant_c = OWN_IF;
    end
  end

  // Transfer FSM: next state, bus payload, completion outputs
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    err_d       = 1'b0;
    cnt_clr_c   = 1'b0;
    cnt_en_c    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_c == OWN_MEM) begin
          owner_d     = OWN_MEM;
          bus_valid_d = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_wstrb_d = mem_wstrb_i;
          state_d     = ST_REQ;
        end else if (grant_c == OWN_IF) begin
          owner_d     = OWN_IF;
          bus_valid_d = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus_ready_i) begin
          bus_valid_d = 1'b0;
          cnt_clr_c   = 1'b1;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        cnt_en_c = 1'b1;
        if (bus_rsp_valid_i) begin
          err_d   = bus_rsp_err_i;
          state_d = ST_DONE;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = bus_rdata_i;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = bus_rdata_i;
            if_done_d  = 1'b1;
          end
        end else if (tmo_expired_c) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = '0;
            mem_done_d  = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end
        end
      end

      ST_DONE: begin
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = owner_q;
`endif
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      err_q       <= err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last completed owner, seeded so MEM wins the first contested grant
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= OWN_IF;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign bus_valid_o = bus_valid_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_wstrb_o = bus_wstrb_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign err_o       = err_q;

  // Pending requests stall their stage until the completion pulse
  assign if_stall_o  = if_req_i & ~if_done_q;
  assign mem_stall_o = mem_req_i & ~mem_done_q;

endmodule
